// File: rtl/signed_accum.sv
// Frame accumulator: sign-extends N-bit samples to M bits, sums K per frame,
// and hands the wrapped sum plus a sticky signed-overflow flag downstream.
module signed_accum #(
    parameter int N = 4,
    parameter int M = 8,
    parameter int K = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_val,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [M-1:0] o_sum,
    output logic         o_ovf
);

    localparam int CW = $clog2(K + 1);

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic signed [M-1:0]   acc_p0, acc_nxt;
    logic signed [M-1:0]   ext, sum;
    logic        [CW-1:0]  cnt, cnt_nxt, cnt_inc;
    logic                  ovf_p0, ovf_nxt;
    logic                  take, give;

    function automatic logic add_ovf(input logic signed [M-1:0] a,
                                     input logic signed [M-1:0] b,
                                     input logic signed [M-1:0] s);
        return (a[M-1] == b[M-1]) && (s[M-1] != a[M-1]);
    endfunction

    generate
        if (M > N) begin : g_ext
            assign ext = {{(M-N){i_val[N-1]}}, i_val};
        end else begin : g_noext
            assign ext = i_val;
        end
    endgenerate

    // Handshakes decode from state only, so no input reaches an output combinationally.
    assign o_ready = (state == ACCUM);
    assign o_valid = (state == OUTPUT);
    assign take    = i_valid & o_ready;
    assign give    = o_valid & i_ready;
    assign sum     = acc_p0 + ext;
    assign cnt_inc = cnt + CW'(1);
    assign o_sum   = acc_p0;
    assign o_ovf   = ovf_p0;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc_p0;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf_p0;
        case (state)
            ACCUM: begin
                if (take) begin
                    acc_nxt = sum;
                    cnt_nxt = cnt_inc;
                    ovf_nxt = ovf_p0 | add_ovf(acc_p0, ext, sum);
                    if (cnt_inc == CW'(K))
                        state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (give) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = ACCUM;
                end
            end
        endcase
    end

    // Stage p0: accumulator, sample count and sticky overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ACCUM;
            acc_p0 <= '0;
            cnt    <= '0;
            ovf_p0 <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc_p0 <= acc_nxt;
            cnt    <= cnt_nxt;
            ovf_p0 <= ovf_nxt;
        end
    end

endmodule
